sequence_generator: RTL and testbench

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/sequence_generator_if.sv | 26 ++
 rtl/sequence_generator.sv | 140 ++++++++++++++
 tb/tb_sequence_generator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_generator_if.sv
// Control and serial-output bundle for sequence_generator.
// master drives the requests; slave (the generator) drives the stream and status.
interface sequence_generator_if #(
   parameter int unsigned SEQ_LEN = 7
);
   logic               load;
   logic [SEQ_LEN-1:0] pattern_in;
   logic               start;
   logic               repeat_en;
   logic               abort;
   logic               x;
   logic               valid;
   logic               busy;
   logic               done;
   logic [7:0]         frame_cnt;

   modport master (
      output load, pattern_in, start, repeat_en, abort,
      input  x, valid, busy, done, frame_cnt
   );

   modport slave (
      input  load, pattern_in, start, repeat_en, abort,
      output x, valid, busy, done, frame_cnt
   );
endinterface

// File: rtl/sequence_generator.sv
// Serial frame generator: shifts a SEQ_LEN-bit pattern out MSB first, optionally repeating
// with GAP_CYCLES idle cycles between frames, and counts completed frames (saturating).
module sequence_generator #(
   parameter int unsigned        SEQ_LEN    = 7,
   parameter logic [SEQ_LEN-1:0] PATTERN    = 7'b1101100,
   parameter int unsigned        GAP_CYCLES = 2
) (
   input logic                 clk,
   input logic                 rst,
   sequence_generator_if.slave bus
);

   localparam int unsigned    CntW    = $clog2(SEQ_LEN);
   localparam logic [CntW-1:0] CntLast = CntW'(SEQ_LEN - 1);
   localparam logic [3:0]     GapLast = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StGap  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [SEQ_LEN-1:0] pattern_q, pattern_d;
   logic [CntW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [3:0]         gap_cnt_q, gap_cnt_d;
   logic               x_q, x_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic [7:0]         frame_cnt_q, frame_cnt_d;
   logic [SEQ_LEN-1:0] frame_pat;

   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      x_d         = 1'b0;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
      frame_pat   = pattern_q;

      unique case (state_q)
         StIdle: begin
            if (!bus.abort) begin
               // A load in the same cycle as start feeds the new pattern straight to x
               if (bus.load) begin
                  pattern_d = bus.pattern_in;
                  frame_pat = bus.pattern_in;
               end
               if (bus.start) begin
                  state_d   = StSend;
                  bit_cnt_d = CntLast;
                  x_d       = frame_pat[SEQ_LEN-1];
                  valid_d   = 1'b1;
               end
            end
         end

         StSend: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else if (bit_cnt_q != '0) begin
               bit_cnt_d = bit_cnt_q - 1'b1;
               x_d       = pattern_q[bit_cnt_d];
               valid_d   = 1'b1;
            end else begin
               if (frame_cnt_q != 8'hFF) begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end
               if (bus.repeat_en) begin
                  if (GAP_CYCLES == 0) begin
                     bit_cnt_d = CntLast;
                     x_d       = pattern_q[SEQ_LEN-1];
                     valid_d   = 1'b1;
                  end else begin
                     state_d   = StGap;
                     gap_cnt_d = GapLast;
                  end
               end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end

         StGap: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else if (gap_cnt_q == 4'd0) begin
               // Once in the gap the next frame is committed, even if repeat_en has dropped
               state_d   = StSend;
               bit_cnt_d = CntLast;
               x_d       = pattern_q[SEQ_LEN-1];
               valid_d   = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern_q   <= PATTERN;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= 4'd0;
         x_q         <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         pattern_q   <= pattern_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         x_q         <= x_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign bus.x         = x_q;
   assign bus.valid     = valid_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = done_q;
   assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: one instance with the default gap, one with
// back-to-back frames for the saturation run.
module tb_sequence_generator;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   logic [6:0] det_sr;
   int   det_hits;

   sequence_generator_if #(.SEQ_LEN(7)) bus_a ();
   sequence_generator_if #(.SEQ_LEN(7)) bus_b ();

   sequence_generator #(
      .SEQ_LEN   (7),
      .PATTERN   (7'b1101100),
      .GAP_CYCLES(2)
   ) dut_a (
      .clk(clk),
      .rst(rst),
      .bus(bus_a)
   );

   sequence_generator #(
      .SEQ_LEN   (7),
      .PATTERN   (7'b1101100),
      .GAP_CYCLES(0)
   ) dut_b (
      .clk(clk),
      .rst(rst),
      .bus(bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks one whole frame on instance A, starting in its first-bit cycle.
   task automatic frame_a(input logic [6:0] pat, input string tag);
      for (int i = 6; i >= 0; i--) begin
         check({tag, "_x"}, 32'(bus_a.x), 32'(pat[i]));
         check({tag, "_valid"}, 32'(bus_a.valid), 32'd1);
         check({tag, "_busy"}, 32'(bus_a.busy), 32'd1);
         det_sr = {det_sr[5:0], bus_a.x};
         if (det_sr == 7'b1101100) det_hits++;
         tick();
      end
   endtask

   task automatic idle_a(input string tag, input logic exp_done, input int exp_cnt);
      check({tag, "_done"}, 32'(bus_a.done), 32'(exp_done));
      check({tag, "_valid"}, 32'(bus_a.valid), 32'd0);
      check({tag, "_x"}, 32'(bus_a.x), 32'd0);
      check({tag, "_busy"}, 32'(bus_a.busy), 32'd0);
      check({tag, "_cnt"}, 32'(bus_a.frame_cnt), 32'(exp_cnt));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      det_sr = '0;
      det_hits = 0;
      rst = 1'b0;
      bus_a.load = 1'b0; bus_a.pattern_in = '0; bus_a.start = 1'b0;
      bus_a.repeat_en = 1'b0; bus_a.abort = 1'b0;
      bus_b.load = 1'b0; bus_b.pattern_in = '0; bus_b.start = 1'b0;
      bus_b.repeat_en = 1'b0; bus_b.abort = 1'b0;

      // Reset state
      #12;
      idle_a("reset", 1'b0, 0);
      check("reset_b_cnt", 32'(bus_b.frame_cnt), 32'd0);
      rst = 1'b1;

      // Default pattern, single frame; start honoured at the first edge after release
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      frame_a(7'b1101100, "dflt");
      idle_a("dflt_end", 1'b1, 1);
      check("dflt_detect", 32'(det_hits), 32'd1);
      tick();
      check("dflt_done_clr", 32'(bus_a.done), 32'd0);

      // Repeat: three frames, repeat_en dropped during the second gap
      bus_a.repeat_en = 1'b1;
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      for (int f = 1; f <= 3; f++) begin
         frame_a(7'b1101100, "rep");
         if (f < 3) begin
            for (int g = 0; g < 2; g++) begin
               check("rep_gap_valid", 32'(bus_a.valid), 32'd0);
               check("rep_gap_x", 32'(bus_a.x), 32'd0);
               check("rep_gap_busy", 32'(bus_a.busy), 32'd1);
               check("rep_gap_done", 32'(bus_a.done), 32'd0);
               check("rep_gap_cnt", 32'(bus_a.frame_cnt), 32'(1 + f));
               if (f == 2 && g == 1) bus_a.repeat_en = 1'b0;
               tick();
            end
         end
      end
      idle_a("rep_end", 1'b1, 4);
      tick();
      check("rep_done_clr", 32'(bus_a.done), 32'd0);

      // Load and start together use the new pattern
      bus_a.load = 1'b1;
      bus_a.start = 1'b1;
      bus_a.pattern_in = 7'b1010101;
      tick();
      bus_a.load = 1'b0;
      bus_a.start = 1'b0;
      frame_a(7'b1010101, "ldst");
      idle_a("ldst_end", 1'b1, 5);
      tick();

      // Load and start while busy are ignored and not queued
      bus_a.start = 1'b1;
      tick();
      bus_a.load = 1'b1;
      bus_a.pattern_in = 7'b0001111;
      frame_a(7'b1010101, "ldbusy");
      bus_a.load = 1'b0;
      bus_a.start = 1'b0;
      idle_a("ldbusy_end", 1'b1, 6);
      tick();
      idle_a("ldbusy_noq", 1'b0, 6);

      // Abort while the third bit is on x
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      check("abort_b1", 32'(bus_a.x), 32'd1);
      tick();
      check("abort_b2", 32'(bus_a.x), 32'd0);
      tick();
      check("abort_b3", 32'(bus_a.x), 32'd1);
      bus_a.abort = 1'b1;
      tick();
      bus_a.abort = 1'b0;
      idle_a("abort", 1'b0, 6);
      tick();
      idle_a("abort_after", 1'b0, 6);

      // Abort in IDLE masks a simultaneous start
      bus_a.abort = 1'b1;
      bus_a.start = 1'b1;
      tick();
      bus_a.abort = 1'b0;
      bus_a.start = 1'b0;
      idle_a("idle_abort", 1'b0, 6);

      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      frame_a(7'b1010101, "post_abort");
      idle_a("post_abort_end", 1'b1, 7);
      tick();

      // Asynchronous reset during bit 4
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      tick();
      tick();
      tick();
      check("rst_b4_valid", 32'(bus_a.valid), 32'd1);
      #2 rst = 1'b0;
      #1;
      idle_a("rst_mid", 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      idle_a("rst_rel", 1'b0, 0);
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      frame_a(7'b1101100, "rst_pat");
      idle_a("rst_pat_end", 1'b1, 1);

      // Back-to-back saturation run on instance B
      bus_b.repeat_en = 1'b1;
      bus_b.start = 1'b1;
      tick();
      bus_b.start = 1'b0;
      for (int f = 1; f <= 260; f++) begin
         for (int i = 6; i >= 0; i--) begin
            logic [6:0] pat_b;
            pat_b = 7'b1101100;
            check("sat_valid", 32'(bus_b.valid), 32'd1);
            check("sat_x", 32'(bus_b.x), 32'(pat_b[i]));
            if (i == 6) begin
               check("sat_cnt", 32'(bus_b.frame_cnt), 32'((f - 1 > 255) ? 255 : f - 1));
               check("sat_done", 32'(bus_b.done), 32'd0);
            end
            if (f == 260 && i == 0) bus_b.repeat_en = 1'b0;
            tick();
         end
      end
      check("sat_end_done", 32'(bus_b.done), 32'd1);
      check("sat_end_valid", 32'(bus_b.valid), 32'd0);
      check("sat_end_cnt", 32'(bus_b.frame_cnt), 32'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
